// File: rtl/branch_ctrl_if.sv
// Instruction-side bus between decode/ALU and branch_ctrl: opcode, branch
// operand, ALU status flags, and the resulting ROM address and taken strobe.
interface branch_ctrl_if #(
    parameter int PC_W = 10
);
    logic [3:0]      op;
    logic [7:0]      target;
    logic            flag_we;
    logic            halt_req;
    logic            z_in;
    logic            neg_in;
    logic            co_in;
    logic [PC_W-1:0] pc;
    logic            taken;

    modport master (
        output op, target, flag_we, halt_req, z_in, neg_in, co_in,
        input  pc, taken
    );

    modport slave (
        input  op, target, flag_we, halt_req, z_in, neg_in, co_in,
        output pc, taken
    );
endinterface

// File: rtl/branch_ctrl.sv
// Program counter, flag register and IDLE/RUN/HALT run controller.
// Optional branch statistics counter enabled by defining BRANCH_STATS_EN.
module branch_ctrl #(
    parameter int         PC_W   = 10,
    parameter logic [3:0] OP_JMP = 4'h8,
    parameter logic [3:0] OP_BRZ = 4'h9,
    parameter logic [3:0] OP_BRN = 4'hA
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    branch_ctrl_if.slave  bus,
    output logic          zf,
    output logic          nf,
    output logic          cf,
    output logic          done
`ifdef BRANCH_STATS_EN
   ,output logic [15:0]   br_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      flags_q, flags_d;
    logic            done_q, done_d;

    logic            is_jmp, is_brz, is_brn;
    logic            branch_hit;
    logic            taken;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] next_pc;

    // Branch decisions use only registered flags, keeping the ALU out of the pc path.
    always_comb begin
        is_jmp     = (bus.op == OP_JMP);
        is_brz     = (bus.op == OP_BRZ);
        is_brn     = (bus.op == OP_BRN);
        branch_hit = is_jmp | (is_brz & flags_q[2]) | (is_brn & flags_q[1]);
        taken      = (state_q == RUN) && !bus.halt_req && branch_hit;
        offset     = PC_W'($signed(bus.target));
        if (is_jmp) begin
            next_pc = PC_W'(bus.target);
        end else if (branch_hit) begin
            next_pc = pc_q + offset;
        end else begin
            next_pc = pc_q + PC_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                pc_d    = '0;
                flags_d = '0;
                done_d  = 1'b0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.flag_we) begin
                    flags_d = {bus.z_in, bus.neg_in, bus.co_in};
                end
                if (bus.halt_req) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else begin
                    pc_d = next_pc;
                end
            end
            HALT: begin
                done_d = 1'b1;
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    flags_d = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                flags_d = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] br_count_q;
    logic        entering_run;

    assign entering_run = (state_q != RUN) && (state_d == RUN);

    // Each new program run starts counting from zero; the count saturates.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            br_count_q <= '0;
        end else if (entering_run) begin
            br_count_q <= '0;
        end else if (taken && (br_count_q != 16'hFFFF)) begin
            br_count_q <= br_count_q + 16'd1;
        end
    end

    assign br_count = br_count_q;
`endif

    assign bus.pc    = pc_q;
    assign bus.taken = taken;
    assign zf        = flags_q[2];
    assign nf        = flags_q[1];
    assign cf        = flags_q[0];
    assign done      = done_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl (PC_W=10); br_count checks are
// included when BRANCH_STATS_EN is defined.
module tb_branch_ctrl;

    localparam int         PC_W   = 10;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BRZ = 4'h9;
    localparam logic [3:0] OP_BRN = 4'hA;

    logic CLK;
    logic reset_n;
    logic start;
    logic zf, nf, cf, done;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count;
`endif

    int check_count;
    int error_count;

    branch_ctrl_if #(.PC_W(PC_W)) bus ();

    branch_ctrl #(
        .PC_W  (PC_W),
        .OP_JMP(OP_JMP),
        .OP_BRZ(OP_BRZ),
        .OP_BRN(OP_BRN)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus.slave),
        .zf      (zf),
        .nf      (nf),
        .cf      (cf),
        .done    (done)
`ifdef BRANCH_STATS_EN
       ,.br_count(br_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] target,
                                 input logic flag_we, input logic z, input logic n,
                                 input logic c, input logic halt_req, input logic st);
        bus.op       = op;
        bus.target   = target;
        bus.flag_we  = flag_we;
        bus.z_in     = z;
        bus.neg_in   = n;
        bus.co_in    = c;
        bus.halt_req = halt_req;
        start        = st;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic nop();
        applyStimulus(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        reset_n     = 1'b0;
        nop();
        repeat (2) @(negedge CLK);

        checkOutput("reset_pc", 32'(bus.pc), 32'd0);
        checkOutput("reset_flags", {29'd0, zf, nf, cf}, 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
`ifdef BRANCH_STATS_EN
        checkOutput("reset_br_count", 32'(br_count), 32'd0);
`endif
        reset_n = 1'b1;

        // Basic run: pc 0 in IDLE, 0 on first RUN cycle, then increments.
        applyStimulus(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("run_first_pc", 32'(bus.pc), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            nop();
            step();
            checkOutput("run_seq_pc", 32'(bus.pc), 32'(i));
        end
        checkOutput("run_done", 32'(done), 32'd0);

        // BRZ taken backward: z written at pc=4, branch at pc=5.
        applyStimulus(OP_NOP, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("zf_set", 32'(zf), 32'd1);
        applyStimulus(OP_BRZ, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("brz_taken", 32'(bus.taken), 32'd1);
        step();
        checkOutput("brz_taken_pc", 32'(bus.pc), 32'd1);

        // BRZ not taken with z cleared.
        repeat (3) begin
            nop();
            step();
        end
        checkOutput("pc_before_brz2", 32'(bus.pc), 32'd4);
        applyStimulus(OP_NOP, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(OP_BRZ, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("brz_not_taken", 32'(bus.taken), 32'd0);
        step();
        checkOutput("brz_not_taken_pc", 32'(bus.pc), 32'd6);

        // Absolute jumps.
        applyStimulus(OP_JMP, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("jmp_to_3", 32'(bus.pc), 32'd3);
        applyStimulus(OP_JMP, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("jmp_taken", 32'(bus.taken), 32'd1);
        step();
        checkOutput("jmp_to_255", 32'(bus.pc), 32'd255);

        // Jump to 0 while writing n=1,c=1; the flags apply to later instructions.
        applyStimulus(OP_JMP, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("jmp_to_0", 32'(bus.pc), 32'd0);
        checkOutput("flags_after_jmp", {29'd0, zf, nf, cf}, 32'b011);

        // Backward BRN below 0 wraps to the top of the ROM, then falls through to 0.
        applyStimulus(OP_BRN, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("brn_wrap_1023", 32'(bus.pc), 32'd1023);
        nop();
        step();
        checkOutput("inc_wrap_0", 32'(bus.pc), 32'd0);
        repeat (2) begin
            nop();
            step();
        end
        applyStimulus(OP_BRN, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("brn_neg128_pc", 32'(bus.pc), 32'd898);

        // BRZ sees old zf=0 even though it writes z=1 itself.
        applyStimulus(OP_BRZ, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("brz_self_flag_taken", 32'(bus.taken), 32'd0);
        step();
        checkOutput("brz_self_flag_pc", 32'(bus.pc), 32'd899);
        checkOutput("brz_self_flag_zf", 32'(zf), 32'd1);

        // Halt wins over a jump; flags still captured on the halting cycle.
        applyStimulus(OP_JMP, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("halt_jmp_taken", 32'(bus.taken), 32'd0);
        step();
        checkOutput("halt_pc_hold", 32'(bus.pc), 32'd899);
        checkOutput("halt_done", 32'(done), 32'd1);
        checkOutput("halt_flags", {29'd0, zf, nf, cf}, 32'b001);

        // Flags frozen while halted.
        applyStimulus(OP_NOP, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("halted_pc", 32'(bus.pc), 32'd899);
        checkOutput("halted_flags", {29'd0, zf, nf, cf}, 32'b001);
        checkOutput("halted_done", 32'(done), 32'd1);

        // Restart from HALT.
        applyStimulus(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("restart_pc", 32'(bus.pc), 32'd0);
        checkOutput("restart_flags", {29'd0, zf, nf, cf}, 32'd0);
        checkOutput("restart_done", 32'(done), 32'd0);

        // start held high is ignored in RUN.
        applyStimulus(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("start_ignored_pc", 32'(bus.pc), 32'd1);
        nop();
        step();
        checkOutput("pc_before_reset", 32'(bus.pc), 32'd2);

        // Asynchronous reset between edges.
        applyStimulus(OP_JMP, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_pc", 32'(bus.pc), 32'd0);
        checkOutput("async_reset_taken", 32'(bus.taken), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        nop();
        step();
        checkOutput("idle_after_reset_pc", 32'(bus.pc), 32'd0);

        // Three taken branches, one not taken, then halt and restart.
        applyStimulus(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        applyStimulus(OP_JMP, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(OP_JMP, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(OP_JMP, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("stats_jmp_pc", 32'(bus.pc), 32'd20);
        applyStimulus(OP_BRZ, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stats_brz_taken", 32'(bus.taken), 32'd0);
        step();
        checkOutput("stats_brz_pc", 32'(bus.pc), 32'd21);
`ifdef BRANCH_STATS_EN
        checkOutput("br_count_3", 32'(br_count), 32'd3);
`endif
        applyStimulus(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("stats_halt_done", 32'(done), 32'd1);
        applyStimulus(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("stats_restart_pc", 32'(bus.pc), 32'd0);
`ifdef BRANCH_STATS_EN
        checkOutput("br_count_cleared", 32'(br_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Program-counter and branch-resolution stage directly downstream of the accumulator ALU. Registers the ALU status outputs (zero, negative, carry) into a flag register, resolves JMP/BRZ/BRN against the registered flags, and drives the next instruction address to the instruction ROM. A three-state run controller sequences start, execution and halt for the top level.

## Interface
- PC_W, default 10: program counter width; instruction ROM depth is 2^PC_W.
- CLK  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level; begins or restarts a program from address 0.
- halt_req  input  1  from decode; current instruction is the program terminator.
- op  input  4  current opcode, same op_mne encoding as the ALU (kJMP, kBRZ, kBRN used here; all others are fall-through).
- target  input  8  branch operand: absolute address for kJMP (zero-extended to PC_W), signed two's-complement offset for kBRZ/kBRN.
- flag_we  input  1  from decode; capture the ALU flags this cycle.
- z_in, neg_in, co_in  input  1 each  ALU outputs z, neg, co.
- pc  output  PC_W  current instruction address.
- zf, nf, cf  output  1 each  registered flags.
- taken  output  1  combinational; branch taken this cycle.
- done  output  1  registered; high while halted.

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: pc held at 0, flags held at 0. start=1 -> RUN on next edge; pc stays 0, so the first RUN cycle executes address 0.
- RUN, per edge, in priority order:
  - halt_req=1 -> HALT; pc holds; flags still update if flag_we=1.
  - Otherwise pc <= next_pc.
- next_pc:
  - kJMP: {0, target}.
  - kBRZ with zf=1, or kBRN with nf=1: pc + sign_extend(target).
  - All other cases: pc + 1.
  - All arithmetic is modulo 2^PC_W; wrap-around is silent, no error.
- taken = (state==RUN) && !halt_req && (kJMP || (kBRZ && zf) || (kBRN && nf)).
- Flag register: in RUN with flag_we=1, {zf,nf,cf} <= {z_in,neg_in,co_in} at the edge.
  - A branch sees flags written by an earlier instruction, never by itself.
  - flag_we on the branch instruction itself updates the flags for later instructions only.
- HALT: done=1; pc and flags frozen.
  - start=1 -> RUN on next edge with pc <= 0 and flags <= 0.
  - start held high through HALT restarts on the following edge.
- start is ignored while in RUN.
- Reset mid-operation: all registers return immediately to their reset values, regardless of CLK.

## Timing
- Reset values: pc=0, zf=nf=cf=0, done=0, state=IDLE; br_count=0 when that feature is present.
- pc is registered; ROM address is valid from the clock edge.
- Single-cycle resolution: no delay slot, no bubble. Instruction at next_pc executes in the cycle after the branch.
- done rises on the edge that enters HALT and falls on the edge that leaves HALT.
- taken is valid in the same cycle as op and depends only on registered flags, so there is no combinational path from the ALU to pc.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds output br_count [15:0], incremented on every edge where taken=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on each IDLE->RUN or HALT->RUN transition.
- Not defined: no br_count port and no counter logic; all other behaviour is identical.

## Test plan
- Basic run: reset, start=1 one cycle, ops non-branch for 5 cycles -> pc sequence 0,0,1,2,3,4; done=0.
- Conditional branches:
  - flag_we=1 with z_in=1 at pc=4, then kBRZ target=8'hFC at pc=5 -> pc=1 next cycle, taken=1.
  - Same sequence with z_in=0 -> pc=6, taken=0.
- Absolute jump and wrap (PC_W=10):
  - kJMP target=8'hFF at pc=3 -> pc=255.
  - At pc=1023, non-branch op -> pc=0.
  - At pc=2, kBRN with nf=1 and target=8'h80 -> pc=898.
- Flag/branch and halt/branch ordering:
  - kBRZ with zf=0 and flag_we=1, z_in=1 in the same cycle -> not taken, zf=1 afterwards.
  - halt_req=1 with kJMP -> pc holds, done=1 next cycle.
- Restart and async reset:
  - In HALT, start=1 -> pc=0, flags=0, done=0 next edge.
  - reset_n low mid-RUN, between clock edges -> pc=0, state IDLE immediately.
- BRANCH_STATS_EN: 3 taken branches followed by 1 not-taken branch -> br_count=3; restart -> br_count=0.
